// File: rtl/sa_input_feeder.sv
// Systolic-array input feeder: streams SRAM rows into a diagonally
// skewed lane pipeline, with a one-entry skid buffer to absorb stalls.
module sa_input_feeder #(
  parameter int DIM    = 4,
  parameter int LANE_W = 4,
  parameter int ADDR_W = 10
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [ADDR_W-1:0]             row_count,
  input  logic                          stall,
  output logic                          sram_rd_en,
  output logic [ADDR_W-1:0]             sram_rd_addr,
  input  logic [DIM*LANE_W-1:0]         sram_rd_data,
  output logic [DIM-1:0][LANE_W-1:0]    feed_out,
  output logic [DIM-1:0]                feed_valid,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [1:0] {
    IDLE, READ, DRAIN, DONE
  } state_t;

  state_t                state;
  logic [ADDR_W-1:0]     base_q;
  logic [ADDR_W-1:0]     cnt_q;
  logic [ADDR_W-1:0]     issued;
  logic                  rd_pend;
  logic                  skid_v;
  logic [DIM*LANE_W-1:0] skid_d;
  logic                  in_v;
  logic [DIM*LANE_W-1:0] in_d;
  logic [DIM-1:0]        lane_busy;
  logic                  last_rd;

  assign sram_rd_en   = (state == READ) && !stall && !skid_v;
  assign sram_rd_addr = base_q + issued;
  assign last_rd      = issued == (cnt_q - ADDR_W'(1));

  // Skid data always wins stage 0 so rows stay in address order.
  assign in_v = !stall && (skid_v || rd_pend);
  assign in_d = !in_v ? '0 :
                skid_v ? skid_d : sram_rd_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_pend <= 1'b0;
      skid_v  <= 1'b0;
      skid_d  <= '0;
    end else begin
      rd_pend <= sram_rd_en;
      if (stall && rd_pend) begin
        skid_v <= 1'b1;
        skid_d <= sram_rd_data;
      end else if (!stall) begin
        skid_v <= 1'b0;
      end
    end
  end

  for (genvar j = 0; j < DIM; j++) begin : g_lane
    logic [LANE_W-1:0] d [j+1];
    logic [j:0]        v;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        v <= '0;
        for (int k = 0; k <= j; k++) d[k] <= '0;
      end else if (!stall) begin
        v[0] <= in_v;
        d[0] <= in_d[j*LANE_W +: LANE_W];
        for (int k = 1; k <= j; k++) begin
          v[k] <= v[k-1];
          d[k] <= d[k-1];
        end
      end
    end

    assign feed_out[j]   = d[j];
    assign feed_valid[j] = v[j];
    assign lane_busy[j]  = |v;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      base_q <= '0;
      cnt_q  <= '0;
      issued <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (!stall) begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            cnt_q  <= row_count;
            issued <= '0;
            busy   <= 1'b1;
            if (row_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (sram_rd_en) begin
            issued <= issued + ADDR_W'(1);
            if (last_rd) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!rd_pend && !skid_v && lane_busy == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_input_feeder.sv
// Scoreboard bench for sa_input_feeder: expected addresses and lane
// data are queued at start, then popped as the DUT reads and emits.
module tb_sa_input_feeder;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [9:0]        base_addr = '0;
  logic [9:0]        row_count = '0;
  logic              stall = 1'b0;
  logic              sram_rd_en;
  logic [9:0]        sram_rd_addr;
  logic [15:0]       sram_rd_data = '0;
  logic [3:0][3:0]   feed_out;
  logic [3:0]        feed_valid;
  logic              busy;
  logic              done;

  sa_input_feeder #(.DIM(4), .LANE_W(4), .ADDR_W(10)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .base_addr(base_addr), .row_count(row_count),
    .stall(stall), .sram_rd_en(sram_rd_en),
    .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
    .feed_out(feed_out), .feed_valid(feed_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [9:0] a);
    return 16'h4321 ^ {4{a[3:0]}};
  endfunction

  always @(posedge clk)
    if (sram_rd_en) sram_rd_data <= mem(sram_rd_addr);

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [9:0] exp_addr [$];
  logic [3:0] exp_lane [4][$];

  int reads_seen, last_rd_cyc, first_rd, done_cnt, done_cyc, busy_cnt;
  int first_v [4];
  int vcnt [4];
  logic [3:0] first_d [4];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en && resetn) begin
      if (sram_rd_en) begin
        reads_seen++;
        last_rd_cyc = cyc;
        if (first_rd < 0) first_rd = cyc;
        checks++;
        if (exp_addr.size() == 0)
          $display("FAIL rd_addr: unexpected read at %h", sram_rd_addr);
        else begin
          logic [9:0] ea;
          ea = exp_addr.pop_front();
          if (sram_rd_addr !== ea)
            $display("FAIL rd_addr: got %h exp %h", sram_rd_addr, ea);
          else passed++;
        end
      end
      for (int j = 0; j < 4; j++) begin
        if (feed_valid[j]) begin
          vcnt[j]++;
          if (first_v[j] < 0) begin
            first_v[j] = cyc;
            first_d[j] = feed_out[j];
          end
          if (!stall) begin
            checks++;
            if (exp_lane[j].size() == 0)
              $display("FAIL lane%0d: extra data %h", j, feed_out[j]);
            else begin
              logic [3:0] ed;
              ed = exp_lane[j].pop_front();
              if (feed_out[j] !== ed)
                $display("FAIL lane%0d: got %h exp %h", j, feed_out[j], ed);
              else passed++;
            end
          end
        end else begin
          checks++;
          if (feed_out[j] !== 4'h0)
            $display("FAIL lane%0d_zero: got %h exp 0", j, feed_out[j]);
          else passed++;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
    end
  end

  task automatic clr();
    exp_addr.delete();
    for (int j = 0; j < 4; j++) begin
      exp_lane[j].delete();
      first_v[j] = -1;
      vcnt[j] = 0;
      first_d[j] = '0;
    end
    reads_seen = 0;
    last_rd_cyc = -1;
    first_rd = -1;
    done_cnt = 0;
    done_cyc = -1;
    busy_cnt = 0;
  endtask

  task automatic expect_tile(input logic [9:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      logic [9:0] a;
      logic [15:0] r;
      a = b + 10'(i);
      r = mem(a);
      exp_addr.push_back(a);
      for (int j = 0; j < 4; j++) exp_lane[j].push_back(r[j*4 +: 4]);
    end
  endtask

  task automatic drive_start(input logic [9:0] b, input logic [9:0] n,
                             output int s);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    row_count = n;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0 && !busy) ok = 1'b1;
    end
  endtask

  task automatic wait_reads(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (reads_seen >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    checks++;
    if ({sram_rd_en, sram_rd_addr, feed_out, feed_valid, busy, done} !== '0)
      $display("FAIL reset: outs %b %h %h %b %b %b exp all 0",
               sram_rd_en, sram_rd_addr, feed_out, feed_valid, busy, done);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    int s;
    bit ok;
    clr();
    expect_tile(10'h010, 3);
    drive_start(10'h010, 10'd3, s);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = 10'h200;
    row_count = 10'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, ok);
    checks++;
    if (!ok) $display("FAIL basic_done: timeout");
    else passed++;
    checks++;
    if (first_rd !== s + 1 || last_rd_cyc !== s + 3 || reads_seen !== 3)
      $display("FAIL basic_reads: first %0d last %0d n %0d exp %0d %0d 3",
               first_rd, last_rd_cyc, reads_seen, s + 1, s + 3);
    else passed++;
    checks++;
    if (first_v[0] !== s + 3 || first_v[3] !== s + 6)
      $display("FAIL basic_skew: v0 %0d v3 %0d exp %0d %0d",
               first_v[0], first_v[3], s + 3, s + 6);
    else passed++;
    checks++;
    if (vcnt[0] !== 3 || vcnt[3] !== 3)
      $display("FAIL basic_vlen: v0 %0d v3 %0d exp 3 3", vcnt[0], vcnt[3]);
    else passed++;
    checks++;
    if (first_d[0] !== 4'h1 || first_d[1] !== 4'h2 ||
        first_d[2] !== 4'h3 || first_d[3] !== 4'h4)
      $display("FAIL basic_lanes: %h %h %h %h exp 1 2 3 4",
               first_d[0], first_d[1], first_d[2], first_d[3]);
    else passed++;
    checks++;
    if (done_cnt !== 1)
      $display("FAIL basic_done_cnt: got %0d exp 1", done_cnt);
    else passed++;
    checks++;
    if (exp_addr.size() != 0 || exp_lane[3].size() != 0)
      $display("FAIL basic_left: addr %0d lane3 %0d exp 0 0",
               exp_addr.size(), exp_lane[3].size());
    else passed++;
  endtask

  task automatic test_zero_rows();
    int s;
    bit ok;
    clr();
    drive_start(10'h055, 10'd0, s);
    wait_done(20, ok);
    checks++;
    if (!ok || reads_seen !== 0)
      $display("FAIL zero_reads: ok %0d reads %0d exp 1 0", ok, reads_seen);
    else passed++;
    checks++;
    if (done_cnt !== 1 || done_cyc !== s + 1)
      $display("FAIL zero_done: cnt %0d cyc %0d exp 1 %0d",
               done_cnt, done_cyc, s + 1);
    else passed++;
    checks++;
    if (busy_cnt !== 1)
      $display("FAIL zero_busy: got %0d exp 1", busy_cnt);
    else passed++;
  endtask

  task automatic test_stall();
    int s;
    bit ok;
    logic [3:0]      sv;
    logic [3:0][3:0] sd;
    clr();
    expect_tile(10'h020, 8);
    drive_start(10'h020, 10'd8, s);
    wait_reads(3, 50, ok);
    checks++;
    if (!ok) $display("FAIL stall_wait: reads %0d exp 3", reads_seen);
    else passed++;
    stall = 1'b1;
    sv = feed_valid;
    sd = feed_out;
    #1;
    checks++;
    if (sram_rd_en !== 1'b0)
      $display("FAIL stall_rd0: got %b exp 0", sram_rd_en);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (feed_valid !== sv || feed_out !== sd || sram_rd_en !== 1'b0)
        $display("FAIL stall_freeze%0d: v %b d %h rd %b exp %b %h 0",
                 i, feed_valid, feed_out, sram_rd_en, sv, sd);
      else passed++;
    end
    stall = 1'b0;
    #1;
    checks++;
    if (sram_rd_en !== 1'b0)
      $display("FAIL stall_skid: rd_en %b exp 0", sram_rd_en);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (sram_rd_en !== 1'b1)
      $display("FAIL stall_resume: rd_en %b exp 1", sram_rd_en);
    else passed++;
    wait_done(100, ok);
    checks++;
    if (!ok || done_cnt !== 1 || reads_seen !== 8)
      $display("FAIL stall_done: ok %0d done %0d reads %0d exp 1 1 8",
               ok, done_cnt, reads_seen);
    else passed++;
    checks++;
    if (exp_lane[0].size() != 0 || exp_lane[3].size() != 0)
      $display("FAIL stall_left: l0 %0d l3 %0d exp 0 0",
               exp_lane[0].size(), exp_lane[3].size());
    else passed++;
  endtask

  task automatic test_wrap();
    int s;
    bit ok;
    clr();
    expect_tile(10'h3FE, 4);
    drive_start(10'h3FE, 10'd4, s);
    wait_done(100, ok);
    checks++;
    if (!ok || reads_seen !== 4 || exp_addr.size() != 0 ||
        exp_lane[3].size() != 0)
      $display("FAIL wrap: ok %0d reads %0d left %0d exp 1 4 0",
               ok, reads_seen, exp_addr.size());
    else passed++;
  endtask

  task automatic test_mid_reset();
    int s;
    bit ok;
    clr();
    expect_tile(10'h100, 6);
    drive_start(10'h100, 10'd6, s);
    wait_reads(2, 50, ok);
    checks++;
    if (!ok) $display("FAIL mreset_wait: reads %0d exp 2", reads_seen);
    else passed++;
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    checks++;
    if ({sram_rd_en, sram_rd_addr, feed_out, feed_valid, busy, done} !== '0)
      $display("FAIL mreset_outs: %b %h %h %b %b %b exp all 0",
               sram_rd_en, sram_rd_addr, feed_out, feed_valid, busy, done);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    clr();
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || reads_seen !== 0)
      $display("FAIL mreset_idle: busy %b reads %0d exp 0 0",
               busy, reads_seen);
    else passed++;
    expect_tile(10'h040, 3);
    drive_start(10'h040, 10'd3, s);
    wait_done(100, ok);
    checks++;
    if (!ok || done_cnt !== 1 || reads_seen !== 3 ||
        exp_lane[3].size() != 0)
      $display("FAIL mreset_again: ok %0d done %0d reads %0d exp 1 1 3",
               ok, done_cnt, reads_seen);
    else passed++;
  endtask

  initial begin
    clr();
    test_reset();
    test_basic();
    test_zero_rows();
    test_stall();
    test_wrap();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sa_input_feeder.md
SA_INPUT_FEEDER -- requirements
Module: sa_input_feeder

Interface
REQ-001 The block SHALL have parameter DIM, default 4: number of systolic lanes (rows of the array input).
REQ-002 The block SHALL have parameter LANE_W, default 4: bits per lane element.
REQ-003 The block SHALL have parameter ADDR_W, default 10: SRAM read address width.
REQ-004 Port clk, input, 1: clock, all state on rising edge.
REQ-005 Port resetn, input, 1: reset, asynchronous, active-low.
REQ-006 Port start, input, 1: single-cycle request to stream a tile; ignored unless state is IDLE.
REQ-007 Port base_addr, input, ADDR_W: first SRAM row address, sampled on accepted start.
REQ-008 Port row_count, input, ADDR_W: number of rows to stream, sampled on accepted start.
REQ-009 Port stall, input, 1: downstream hold; freezes reads, skew pipeline and outputs.
REQ-010 Port sram_rd_en, output, 1: SRAM read strobe.
REQ-011 Port sram_rd_addr, output, ADDR_W: SRAM read address.
REQ-012 Port sram_rd_data, input, DIM*LANE_W: read data, valid exactly 1 cycle after sram_rd_en; lane j = bits [j*LANE_W +: LANE_W].
REQ-013 Port feed_out, output, DIM x LANE_W: skewed lane data to array left inputs.
REQ-014 Port feed_valid, output, DIM: per-lane valid.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: single-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, READ, DRAIN, DONE.
REQ-018 IDLE -> READ on start with row_count != 0; IDLE -> DONE on start with row_count == 0 (no reads issued).
REQ-019 In READ, sram_rd_en SHALL be high on every cycle where stall is low and the skid register is empty, with sram_rd_addr = base_addr + rows_issued (mod 2^ADDR_W); rows_issued increments per read.
REQ-020 READ -> DRAIN in the cycle after the read for row row_count-1 is issued.
REQ-021 DRAIN -> DONE when no read is outstanding, the skid register is empty and all feed_valid bits are 0.
REQ-022 DONE SHALL last exactly one cycle with done=1, then go to IDLE; done SHALL be 0 in all other states.
REQ-023 Returned data SHALL enter skew stage 0 on its arrival cycle (stall low); lane j SHALL pass through j additional registers, so with no stall row k read at cycle t appears on feed_out[j] with feed_valid[j]=1 at cycle t+2+j.
REQ-024 feed_out[j] SHALL be 0 whenever feed_valid[j] is 0.
REQ-025 While stall is high, all skew registers, feed_out, feed_valid, rows_issued and FSM state SHALL hold, and sram_rd_en SHALL be 0.
REQ-026 Data returning while stall is high SHALL be captured in a one-entry skid register and injected into stage 0 on the first cycle stall is low, before any new read data; no read is issued while the skid register is full.
REQ-027 With stall low and no pipeline bubble, the block SHALL sustain one row per cycle.
REQ-028 Rows SHALL be emitted in address order; no row SHALL be dropped or duplicated under any stall pattern.
REQ-029 start while busy is high SHALL have no effect.
REQ-030 Address SHALL wrap modulo 2^ADDR_W without error.

Reset
REQ-031 On resetn low, at any time including mid-tile, the block SHALL asynchronously clear: state=IDLE, sram_rd_en=0, sram_rd_addr=0, feed_out=0, feed_valid=0, busy=0, done=0, skid empty, rows_issued=0.
REQ-032 After reset release the block SHALL wait in IDLE for a new start; the interrupted tile is not resumed.

Verification
REQ-033 start, base_addr=0x010, row_count=3, stall=0 -> reads at 0x010,0x011,0x012 on consecutive cycles; feed_valid[0] high 3 cycles starting 2 cycles after first read; feed_valid[3] starts 3 cycles later; one done pulse.
REQ-034 SRAM row data 0x4321 -> feed_out[0]=1, [1]=2, [2]=3, [3]=4, each on its skewed cycle.
REQ-035 start, row_count=0 -> no sram_rd_en, done pulses the cycle after start, busy high exactly 1 cycle.
REQ-036 row_count=8, stall high for 2 cycles right after the 3rd read -> skid used, outputs frozen, all 8 rows emitted in order with no loss or duplication.
REQ-037 base_addr=0x3FE, row_count=4 -> addresses 0x3FE,0x3FF,0x000,0x001.
REQ-038 resetn low during READ of a 6-row tile -> all outputs 0 immediately; second start after release completes normally.
